// File: rtl/shift_add_mult.sv
// Sequential 8x8 unsigned shift-and-add multiplier built on multi_adder.
// Optional: SHIFT_ADD_MULT_ZERO_BYPASS_EN skips RUN for zero operands.

module multi_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       c
);
    logic [8:0] cy;

    assign cy[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_fa
            assign sum[i]  = a[i] ^ b[i] ^ cy[i];
            assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign c = cy[8];
endmodule

module shift_add_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  mcand;
    logic [16:0] acc;
    logic [2:0]  cnt;
    logic [7:0]  sum;
    logic        c;
    logic [15:0] step_acc;

    multi_adder u_add (
        .a   (acc[15:8]),
        .b   (mcand),
        .cin (1'b0),
        .sum (sum),
        .c   (c)
    );

    // Carry lands in bit 15 after the shift, so the product never overflows.
    always_comb begin
        step_acc = '0;
        if (acc[0])
            step_acc = {c, sum, acc[7:1]};
        else
            step_acc = acc[16:1];
    end

`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (a == 8'h00) || (b == 8'h00);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        acc   <= {9'h000, b};
                        cnt   <= '0;
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
                        if (zero_op) begin
                            state   <= DONE;
                            product <= '0;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc <= {1'b0, step_acc};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state   <= DONE;
                        product <= step_acc;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult against a plain a*b reference.
// Directed cases from the datapath plan plus randomized operand pairs.

module tb_shift_add_mult;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int total;
    int bad;

`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    shift_add_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input int hold, input string tag);
        int lat;
        int bz;
        int exp_lat;
        logic [15:0] exp;
        exp     = 16'(ta) * 16'(tb);
        exp_lat = (BYPASS && (ta == 0 || tb == 0)) ? 0 : 8;
        wait_ready(tag);
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        bz  = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bz++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(bz), 32'(exp_lat));
        chk({tag, " product"}, 32'(product), 32'(exp));
        chk({tag, " ready_in_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_product"}, 32'(product), 32'(exp));
            chk({tag, " hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " released"}, 32'(out_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " kept_product"}, 32'(product), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst product", 32'(product), 32'd0);

        run_op(8'h0D, 8'h0B, 0, "d_0d0b");
        chk("d_0d0b value", 32'(product), 32'h008F);
        run_op(8'hFF, 8'hFF, 0, "d_ffff");
        chk("d_ffff value", 32'(product), 32'hFE01);
        run_op(8'h80, 8'h03, 5, "d_8003");
        chk("d_8003 value", 32'(product), 32'h0180);

        // abort mid-RUN: reset is sampled on the 4th RUN edge
        wait_ready("abort");
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort product", 32'(product), 32'd0);
        run_op(8'h02, 8'h03, 0, "d_0203");

        // in_valid during RUN must be ignored, then accepted once idle
        wait_ready("ign");
        a = 8'h03;
        b = 8'h05;
        in_valid = 1'b1;
        tick();
        a = 8'h55;
        b = 8'h55;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("ign first", 32'(product), 32'h000F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ign idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("ign accepted", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("ign second", 32'(product), 32'h1C39);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        run_op(8'h00, 8'h9A, 0, "d_009a");
        run_op(8'h37, 8'h00, 1, "d_3700");

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 8'h00;
            run_op(ra, rb, int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
